spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  Parametrised SPI mode-0 peripheral: register bank with read-back over MISO.
//  Generalises the fixed 5x8-bit write-only peripheral.
//  Width and depth are set by parameters. Reads are supported on MISO.
//  Per-write strobes and a frame-error counter are provided.
//  Sits between the chip pins (s_clk/cs/mosi/miso) and the config consumers (PWM, etc.).
// PARAMETERS
//  NUM_REGS   5   number of registers; valid addresses are 0..NUM_REGS-1
//  ADDR_W     7   address field width; must satisfy 2**ADDR_W >= NUM_REGS
//  DATA_W     8   register/data field width
//  SYNC_STG   2   synchroniser depth on s_clk, cs and mosi (minimum 2)
// PORTS
//  m_clk      in   1                  system clock; must be >= 8x the s_clk frequency
//  rst_n      in   1                  async active-low reset
//  s_clk      in   1                  SPI clock (CPOL=0, CPHA=0), asynchronous to m_clk
//  cs         in   1                  chip select, active-low
//  mosi       in   1                  serial data in, MSB first
//  miso       out  1                  serial data out, MSB first
//  miso_oe    out  1                  MISO output enable (pad tristate control)
//  regs       out  NUM_REGS*DATA_W    flat register bank; reg i = regs[i*DATA_W +: DATA_W]
//  wr_stb     out  1                  one-cycle pulse when a write commits
//  wr_addr    out  ADDR_W             address of the last committed write
//  err_cnt    out  8                  count of discarded frames, saturating at 8'hFF
// BEHAVIOUR
//  Reset (async assert, sync deassert on m_clk):
//   - regs, wr_addr and err_cnt reset to 0.
//   - wr_stb, miso and miso_oe reset to 0.
//   - FSM goes to IDLE; shifter and bit counter are cleared.
//  Input path and edge detection:
//   - s_clk, cs and mosi pass through SYNC_STG flops.
//   - Edges (sclk_rise, sclk_fall, cs_fall, cs_rise) are detected one cycle later.
//   - Edges are processed only in the synchronised m_clk domain; there are no other clock domains.
//  Frame format: L = 1+ADDR_W+DATA_W bits, formatted as {rw, addr, data}.
//   - rw=1 is a write; rw=0 is a read.
//  FSM states and transitions:
//   - IDLE -> ADDR on cs_fall.
//   - ADDR: shift mosi in on each sclk_rise.
//   - ADDR -> DATA after 1+ADDR_W bits.
//   - On entry to DATA with rw=0: load the shifter with the register value (0 if the address >= NUM_REGS).
//     miso = MSB immediately.
//     Each later sclk_fall shifts the next bit out.
//   - DATA: write frames continue sampling mosi on sclk_rise.
//   - Any state -> IDLE on cs_rise.
//  miso_oe: 1 only while cs is low in DATA of a read frame. When miso_oe=0, miso=0.
//  Write commit, at cs_rise:
//   - Commits only when bit count == L, rw=1 and addr < NUM_REGS.
//   - The register updates and wr_stb pulses on the same m_clk edge.
//   - Latency: SYNC_STG+1 m_clk edges after the cs pin rises.
//  Write ignored, no error (well-formed frame):
//   - Write with addr >= NUM_REGS.
//   - Read of any length == L.
//  Frame error: count != L at cs_rise (short or long).
//   - The frame is discarded and err_cnt increments (saturating).
//   - Bits beyond L are ignored, but the counter keeps incrementing to flag the overlength.
//   - The counter saturates at L+1.
//  Simultaneous events:
//   - cs_rise takes priority over a same-cycle sclk edge.
//   - cs_fall in the same cycle as cs_rise is impossible after the sync stage.
//   - sclk edges while in IDLE are ignored.
//   - A cs_fall while not in IDLE restarts the frame.
//  Reset mid-frame: the frame is abandoned with no commit and no err_cnt change.
//  regs hold their value across frames and are never cleared except by reset.
// STRUCTURE
//  Package spi_pkg:
//   - FSM enum (IDLE, ADDR, DATA).
//   - RW_WRITE=1'b1.
//   - Function frame_len(addr_w, data_w).
//  Sub-module spi_sync: parametrised-depth bit synchroniser, instantiated once for each of s_clk, cs and mosi.
//  Top level holds: edge detectors, the FSM, one shared SHIFT register (L bits), the bit counter, the bank and err_cnt.
// TESTING (defaults; m_clk 50 MHz, s_clk 1 MHz)
//  1. Write 0x80_A5:
//     -> reg0=0xA5.
//     -> wr_stb pulses exactly once, with wr_addr=0.
//     -> All other regs remain 0.
//  2. Write 0x84_3C, then read 0x04_00:
//     -> miso returns 0x3C during the data phase.
//     -> miso_oe is high only in the data phase.
//     -> regs are unchanged.
//  3. Write 0x85_FF (addr 5):
//     -> No reg changes, no wr_stb, err_cnt=0.
//     -> A read of addr 5 returns 0x00.
//  4. 15-bit frame, then 17-bit frame, both rw=1, addr 1:
//     -> reg1 stays 0; err_cnt=2.
//  5. Assert rst_n low after 9 bits of a write to reg2 (reg2 previously 0x11):
//     -> regs are all 0.
//     -> The next full write 0x82_22 gives reg2=0x22.
//  6. Back-to-back frames with a 2-m_clk cs-high gap:
//     -> Both commit.
//     -> 256 bad frames leave err_cnt=0xFF.

Source files
------------

// File: rtl/spi_reg_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pkg : shared types and helpers for the SPI register bank             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;

    // Frame is {rw, addr, data}
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_sync : parametrised-depth single-bit synchroniser into m_clk         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_reg_bank : SPI mode-0 peripheral with a read/write register bank     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic                       m_clk,
    input  logic                       rst_n,
    input  logic                       s_clk,
    input  logic                       cs,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 err_cnt
);

    localparam int c_frame_len = frame_len(ADDR_W, DATA_W);
    localparam int c_hdr_len   = 1 + ADDR_W;
    localparam int c_cnt_w     = $clog2(c_frame_len + 2);

    localparam logic [c_cnt_w-1:0] c_cnt_full   = c_cnt_w'(c_frame_len);
    localparam logic [c_cnt_w-1:0] c_cnt_sat    = c_cnt_w'(c_frame_len + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_hdr    = c_cnt_w'(c_hdr_len);
    localparam logic [c_cnt_w-1:0] c_cnt_hdr_m1 = c_cnt_w'(c_hdr_len - 1);

    // Reset: asserts asynchronously, releases on m_clk
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    spi_sync #(.STAGES(SYNC_STG)) u_sync_sclk (
        .clk   (m_clk),
        .rst_n (w_rst_n),
        .i_d   (s_clk),
        .o_q   (w_sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STG)) u_sync_cs (
        .clk   (m_clk),
        .rst_n (w_rst_n),
        .i_d   (cs),
        .o_q   (w_cs_s)
    );

    spi_sync #(.STAGES(SYNC_STG)) u_sync_mosi (
        .clk   (m_clk),
        .rst_n (w_rst_n),
        .i_d   (mosi),
        .o_q   (w_mosi_s)
    );

    // cs history resets low so a reset released mid-frame never sees a cs_fall
    logic r_sclk_d;
    logic r_cs_d;

    always_ff @(posedge m_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;

    spi_state_t               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_frame_len-1:0]   r_shift;
    logic                     r_rw;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_miso;
    logic                     r_miso_oe;
    logic                     r_wr_stb;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic [7:0]               r_err;
    logic [DATA_W-1:0]        r_bank [NUM_REGS];

    logic [c_frame_len-1:0]   w_shift_in;
    logic [c_frame_len-1:0]   w_shift_out;
    logic [ADDR_W:0]          w_hdr;
    logic [DATA_W-1:0]        w_rd_data;
    logic                     w_addr_ok;
    logic                     w_commit;

    assign w_shift_in  = {r_shift[c_frame_len-2:0], w_mosi_s};
    assign w_shift_out = r_shift << 1;
    // Header as it stands once the current sclk_rise bit is included
    assign w_hdr       = {r_shift[ADDR_W-1:0], w_mosi_s};
    assign w_addr_ok   = 32'(r_addr) < 32'(NUM_REGS);
    assign w_commit    = w_cs_rise && (r_state != IDLE) && (r_cnt == c_cnt_full)
                         && (r_rw == RW_WRITE) && w_addr_ok;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hdr[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_rd_data = r_bank[i];
            end
        end
    end

    always_ff @(posedge m_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_err     <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_cs_rise) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
                if (r_state != IDLE) begin
                    if (w_commit) begin
                        r_wr_stb  <= 1'b1;
                        r_wr_addr <= r_addr;
                    end else if (r_cnt != c_cnt_full && r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end
            end else if (w_cs_fall) begin
                r_state   <= ADDR;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == c_cnt_hdr_m1) begin
                                r_state <= DATA;
                                r_rw    <= w_hdr[ADDR_W];
                                r_addr  <= w_hdr[ADDR_W-1:0];
                                if (w_hdr[ADDR_W] != RW_WRITE) begin
                                    r_shift   <= {w_hdr, w_rd_data};
                                    r_miso    <= w_rd_data[DATA_W-1];
                                    r_miso_oe <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (w_sclk_rise) begin
                            if (r_cnt < c_cnt_full && r_rw == RW_WRITE) begin
                                r_shift <= w_shift_in;
                            end
                            if (r_cnt != c_cnt_sat) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        // The fall right after the header must keep the MSB on the pin
                        end else if (w_sclk_fall && r_rw != RW_WRITE && r_cnt > c_cnt_hdr) begin
                            r_shift <= w_shift_out;
                            r_miso  <= w_shift_out[DATA_W-1];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge m_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    r_bank[i] <= r_shift[DATA_W-1:0];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs[gi*DATA_W +: DATA_W] = r_bank[gi];
    end

    assign miso    = r_miso;
    assign miso_oe = r_miso_oe;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign err_cnt = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_reg_bank : directed table, randomized frames and corner sequences |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_spi_reg_bank;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int SYNC_STG = 2;
    localparam int L        = 1 + ADDR_W + DATA_W;
    localparam int HALF     = 500;
    localparam int LAT_WIN  = SYNC_STG + 3;

    logic                       m_clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       s_clk = 1'b0;
    logic                       cs    = 1'b1;
    logic                       mosi  = 1'b0;
    logic                       miso;
    logic                       miso_oe;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       wr_stb;
    logic [ADDR_W-1:0]          wr_addr;
    logic [7:0]                 err_cnt;

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .m_clk   (m_clk),
        .rst_n   (rst_n),
        .s_clk   (s_clk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .regs    (regs),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .err_cnt (err_cnt)
    );

    always #10 m_clk = ~m_clk;

    int checks = 0;
    int errors = 0;
    int stb_total = 0;

    always @(negedge m_clk) begin
        if (wr_stb === 1'b1) stb_total++;
    end

    // Reference model state
    logic [DATA_W-1:0] mdl_regs [NUM_REGS];
    int                mdl_err;
    int                mdl_wr_addr;

    typedef struct {
        int                n;
        logic [31:0]       v;
        bit                exp_stb;
        bit                is_rd;
        logic [DATA_W-1:0] exp_rd;
        logic [7:0]        exp_err;
        int                chk_idx;
        logic [DATA_W-1:0] chk_val;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = '0;
        mdl_err     = 0;
        mdl_wr_addr = 0;
    endtask

    task automatic model_frame(input int n, input logic [31:0] v,
                               output bit commit, output bit is_rd,
                               output logic [DATA_W-1:0] rd);
        int rw;
        int addr;
        commit = 1'b0;
        is_rd  = 1'b0;
        rd     = '0;
        if (n != L) begin
            if (mdl_err < 255) mdl_err++;
        end else begin
            rw   = int'((v >> (L - 1)) & 32'd1);
            addr = int'((v >> DATA_W) & ((32'd1 << ADDR_W) - 32'd1));
            if (rw == 1) begin
                if (addr < NUM_REGS) begin
                    mdl_regs[addr] = v[DATA_W-1:0];
                    mdl_wr_addr    = addr;
                    commit         = 1'b1;
                end
            end else begin
                is_rd = 1'b1;
                rd    = (addr < NUM_REGS) ? mdl_regs[addr] : '0;
            end
        end
    endtask

    // Master side: mosi changes while s_clk is low, miso sampled just before each rise
    task automatic shift_bits(input int n, input logic [31:0] v,
                              output logic [DATA_W-1:0] rd, output int oe_bad);
        logic exp_oe;
        rd     = '0;
        oe_bad = 0;
        for (int i = 0; i < n; i++) begin
            mosi = v[n-1-i];
            #HALF;
            exp_oe = (v[n-1] == 1'b0) && (i > ADDR_W);
            if (miso_oe !== exp_oe) oe_bad++;
            if (miso_oe !== 1'b1 && miso !== 1'b0) oe_bad++;
            if (i > ADDR_W && i < L) rd = {rd[DATA_W-2:0], miso};
            s_clk = 1'b1;
            #HALF;
            s_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input logic [31:0] v, input int gap,
                             output logic [DATA_W-1:0] rd, output int oe_bad, output int lat);
        cs = 1'b0;
        #HALF;
        shift_bits(n, v, rd, oe_bad);
        #HALF;
        @(posedge m_clk); #1;
        cs  = 1'b1;
        lat = 0;
        for (int e = 1; e <= LAT_WIN; e++) begin
            @(posedge m_clk); #1;
            if (wr_stb === 1'b1 && lat == 0) lat = e;
            if (e == gap) cs = 1'b0;
        end
        if (miso_oe !== 1'b0 || miso !== 1'b0) oe_bad++;
        for (int e = LAT_WIN; e < gap; e++) begin
            @(posedge m_clk); #1;
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s reg%0d", tag, i), regs[i*DATA_W +: DATA_W], mdl_regs[i]);
    endtask

    task automatic run_frame(input string tag, input int n, input logic [31:0] v, input int gap,
                             output logic [DATA_W-1:0] rd);
        bit                commit;
        bit                is_rd;
        logic [DATA_W-1:0] exp_rd;
        int                oe_bad;
        int                lat;
        int                s0;
        model_frame(n, v, commit, is_rd, exp_rd);
        s0 = stb_total;
        spi_frame(n, v, gap, rd, oe_bad, lat);
        check({tag, " stb_latency"}, lat, commit ? SYNC_STG + 1 : 0);
        check({tag, " stb_pulses"}, stb_total - s0, commit ? 1 : 0);
        check({tag, " miso_oe"}, oe_bad, 0);
        if (is_rd) check({tag, " read_data"}, rd, exp_rd);
        check({tag, " err_cnt"}, err_cnt, mdl_err);
        check({tag, " wr_addr"}, wr_addr, mdl_wr_addr);
        check_bank(tag);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic [31:0]       v;
        int                n;
        int                oe_bad;
        int                lat;
        int                s0;
        bit                c;
        bit                r;

        //            n   frame       stb rd  exp_rd  err  idx val
        vecs[0] = '{16, 32'h80A5,    1, 0, 8'h00, 8'd0, 0, 8'hA5};
        vecs[1] = '{16, 32'h843C,    1, 0, 8'h00, 8'd0, 4, 8'h3C};
        vecs[2] = '{16, 32'h0400,    0, 1, 8'h3C, 8'd0, 4, 8'h3C};
        vecs[3] = '{16, 32'h85FF,    0, 0, 8'h00, 8'd0, 0, 8'hA5};
        vecs[4] = '{16, 32'h0500,    0, 1, 8'h00, 8'd0, 4, 8'h3C};
        vecs[5] = '{15, 32'h40D5,    0, 0, 8'h00, 8'd1, 1, 8'h00};
        vecs[6] = '{17, 32'h10355,   0, 0, 8'h00, 8'd2, 1, 8'h00};

        model_reset();
        repeat (5) @(posedge m_clk);
        #1;
        check("reset regs", regs, 0);
        check("reset wr_stb", wr_stb, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset err_cnt", err_cnt, 0);
        check("reset miso", miso, 0);
        check("reset miso_oe", miso_oe, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge m_clk);
        #1;
        check("post-reset err_cnt", err_cnt, 0);

        for (int k = 0; k < 7; k++) begin
            s0 = stb_total;
            run_frame($sformatf("vec%0d", k), vecs[k].n, vecs[k].v, 20, rd);
            check($sformatf("vec%0d tbl_stb", k), stb_total - s0, vecs[k].exp_stb);
            if (vecs[k].is_rd) check($sformatf("vec%0d tbl_rd", k), rd, vecs[k].exp_rd);
            check($sformatf("vec%0d tbl_err", k), err_cnt, vecs[k].exp_err);
            check($sformatf("vec%0d tbl_reg", k),
                  regs[vecs[k].chk_idx*DATA_W +: DATA_W], vecs[k].chk_val);
        end

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    n = L;
                    v = ($urandom_range(0, 1) << (L - 1)) | ($urandom_range(0, 7) << DATA_W)
                        | $urandom_range(0, 255);
                end
                6, 7: begin
                    n = $urandom_range(0, L - 1);
                    v = $urandom & ((32'd1 << n) - 32'd1);
                end
                default: begin
                    n = $urandom_range(L + 1, L + 4);
                    v = $urandom & ((32'd1 << n) - 32'd1);
                end
            endcase
            run_frame($sformatf("rnd%0d n=%0d v=%0h", k, n, v), n, v, 20, rd);
        end

        // Reset in the middle of a write to reg2
        run_frame("pre-reset wr", 16, 32'h8211, 20, rd);
        cs = 1'b0;
        #HALF;
        shift_bits(9, 32'h104, rd, oe_bad);
        rst_n = 1'b0;
        model_reset();
        #100;
        check("midreset regs", regs, 0);
        check("midreset err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        #100;
        s0 = stb_total;
        shift_bits(7, 32'h33, rd, oe_bad);
        check("postreset miso_oe", oe_bad, 0);
        #HALF;
        @(posedge m_clk); #1;
        cs = 1'b1;
        repeat (LAT_WIN + 5) @(posedge m_clk);
        #1;
        check("abandoned regs", regs, 0);
        check("abandoned err_cnt", err_cnt, 0);
        check("abandoned stb", stb_total - s0, 0);
        run_frame("post-reset wr", 16, 32'h8222, 20, rd);
        check("post-reset reg2", regs[2*DATA_W +: DATA_W], 8'h22);

        // Back-to-back with a 2-cycle cs-high gap
        run_frame("b2b_a", 16, 32'h835A, 2, rd);
        run_frame("b2b_b", 16, 32'h8099, 20, rd);
        check("b2b reg3", regs[3*DATA_W +: DATA_W], 8'h5A);
        check("b2b reg0", regs[0*DATA_W +: DATA_W], 8'h99);

        // Empty frames drive err_cnt into saturation
        s0 = stb_total;
        for (int k = 0; k < 256; k++) begin
            model_frame(0, 32'h0, c, r, rd);
            spi_frame(0, 32'h0, 0, rd, oe_bad, lat);
            if (k == 254) check("err_cnt at 255 frames", err_cnt, mdl_err);
        end
        check("err_cnt saturated", err_cnt, 8'hFF);
        check("err_cnt model", err_cnt, mdl_err);
        check("bad frames stb", stb_total - s0, 0);
        check_bank("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
